code_wp_bank: RTL and testbench
===============================

Name: code_wp_bank

Overview:
- Multi-region successor to the single-bit code write-protect latch.
- Holds NREG independent sticky write-1-to-set protect bits, each covering one power-of-two-sized slice of code storage.
- Screens every code-storage write against them and records blocked writes (first address, saturating count, IRQ).
- Sits between the code-storage write port and the storage array. Set sources are the CSR LOCK bit and the MMIO control register.

Parameters:
NREG, 4, number of protect regions (1..32)
AW, 32, write address width
REGION_BASE, 32'h0000_0000, byte address of region 0
REGION_SHIFT, 12, log2 of region size in bytes (all regions equal size)
BOOT_MASK, 4'b0001, regions auto-protected one cycle after reset when not in manufacturing mode (width NREG)
CNT_W, 8, violation counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
lock_i  in  1  sticky system LOCK; while 1, sets all protect bits
wp_set_i  in  1  MMIO write strobe, one cycle
wp_set_mask_i  in  NREG  write-1-to-set mask, qualified by wp_set_i
manuf_mode_i  in  1  1 = factory mode, suppresses BOOT_MASK auto-set
wr_valid_i  in  1  code-storage write request
wr_addr_i  in  AW  write byte address
wr_block_o  out  1  combinational: current write must be dropped
wp_q  out  NREG  protect bits
viol_pending_o  out  1  sticky violation flag / level IRQ
viol_addr_o  out  AW  address of first violation since last clear
viol_cnt_o  out  CNT_W  saturating count of blocked writes
viol_clr_i  in  1  one-cycle pulse: clear pending, address and count

Behaviour:
- Reset is asynchronous and active-low, on rst_n. While rst_n=0:
  - wp_q=0, viol_pending_o=0, viol_addr_o=0, viol_cnt_o=0.
  - Internal boot_done=0.
- Boot step: on the first clk edge after reset release, boot_done<=1. In that same edge, if manuf_mode_i=0, BOOT_MASK is ORed into the wp_q update. manuf_mode_i is ignored after that edge.
- wp_q update on each edge: wp_q <= wp_q | ({NREG{lock_i}}) | (wp_set_i ? wp_set_mask_i : 0) | boot term.
  - Bits never clear except through rst_n.
  - Setting an already-set bit has no effect.
- Region decode:
  - off = wr_addr_i - REGION_BASE, computed in AW bits with no wrap allowance.
  - in_range = (wr_addr_i >= REGION_BASE) && ((off >> REGION_SHIFT) < NREG).
  - idx = off >> REGION_SHIFT.
- wr_block_o = wr_valid_i & in_range & wp_q[idx]. It uses the registered wp_q, so a set that is effective in cycle N blocks writes from cycle N+1. A write in the same cycle as its region's set strobe passes.
- Out-of-range writes are never blocked or counted.
- Violation bookkeeping, on an edge where wr_block_o=1:
  - viol_cnt_o increments, saturating at 2^CNT_W-1.
  - If viol_pending_o=0, viol_addr_o<=wr_addr_i and viol_pending_o<=1.
  - If viol_pending_o=1, viol_addr_o holds. This keeps the first address.
- viol_clr_i alone: pending<=0, addr<=0, cnt<=0 on the next edge.
- viol_clr_i together with a blocked write in the same cycle: the clear applies first, then the new violation. Result: pending=1, addr=new address, cnt=1.
- Reset mid-operation clears everything asynchronously, including protect bits. The boot step then re-runs.

Test Plan:
- Reset release with manuf_mode_i=0, defaults -> wp_q=4'b0000 during reset, 4'b0001 after first edge. A write to 0x0000_0010 one cycle later gives wr_block_o=1, viol_addr_o=0x10, viol_cnt_o=1, viol_pending_o=1.
- Reset release with manuf_mode_i=1 -> wp_q stays 0. A write to 0x0 is not blocked. Then wp_set_i=1 with mask 4'b0100 -> wp_q=4'b0100 next cycle. A write to 0x2000 is blocked; a write to 0x1000 passes.
- lock_i=1 for one cycle, then 0 -> wp_q=4'b1111 and it remains so for 100 cycles. wp_set_i with mask 0 does not change it.
- Blocked write in the same cycle as viol_clr_i, with prior cnt=5 and addr=0x10 -> next cycle pending=1, addr=new address, cnt=1.
- 300 blocked writes with CNT_W=8 -> viol_cnt_o saturates at 255. viol_addr_o still equals the first address.
- Write to 0x4000 (idx 4, out of range), then wp_set_i mask 4'b0010 with a same-cycle write to 0x1000 -> neither write is blocked. The write to 0x1000 in the next cycle is blocked.

Source files
------------

// File: rtl/code_wp_bank.sv
`default_nettype none
// ============================================================================
// Module      : code_wp_bank
// Description : NREG sticky write-1-to-set code write-protect bits with
//               write screening and blocked-write bookkeeping (addr/count/IRQ).
// Revision    : 1.0 - initial release
// ============================================================================
module code_wp_bank #(
    parameter int              NREG         = 4,
    parameter int              AW           = 32,
    parameter logic [AW-1:0]   REGION_BASE  = '0,
    parameter int              REGION_SHIFT = 12,
    parameter logic [NREG-1:0] BOOT_MASK    = NREG'(1),
    parameter int              CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lock_i,
    input  logic             wp_set_i,
    input  logic [NREG-1:0]  wp_set_mask_i,
    input  logic             manuf_mode_i,
    input  logic             wr_valid_i,
    input  logic [AW-1:0]    wr_addr_i,
    output logic             wr_block_o,
    output logic [NREG-1:0]  wp_q,
    output logic             viol_pending_o,
    output logic [AW-1:0]    viol_addr_o,
    output logic [CNT_W-1:0] viol_cnt_o,
    input  logic             viol_clr_i
);

    localparam logic [AW-1:0]    c_nreg_aw = AW'(NREG);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [AW-1:0]    w_off;
    logic [AW-1:0]    w_idx;
    logic             w_in_range;
    logic [NREG-1:0]  w_region_hit;

    logic             boot_done_q,    boot_done_d;
    logic [NREG-1:0]  wp_d;
    logic             viol_pending_q, viol_pending_d;
    logic [AW-1:0]    viol_addr_q,    viol_addr_d;
    logic [CNT_W-1:0] viol_cnt_q,     viol_cnt_d;

    // Region decode: addresses below the base or past the last region map nowhere.
    always_comb begin
        w_off      = wr_addr_i - REGION_BASE;
        w_idx      = w_off >> REGION_SHIFT;
        w_in_range = (wr_addr_i >= REGION_BASE) && (w_idx < c_nreg_aw);
    end

    for (genvar i = 0; i < NREG; i++) begin : g_hit
        assign w_region_hit[i] = w_in_range && (w_idx == AW'(i));
    end

    assign wr_block_o = wr_valid_i & (|(w_region_hit & wp_q));

    always_comb begin
        boot_done_d = 1'b1;
        wp_d        = wp_q
                    | {NREG{lock_i}}
                    | (wp_set_i ? wp_set_mask_i : '0)
                    | ((!boot_done_q && !manuf_mode_i) ? BOOT_MASK : '0);

        // A clear takes effect before a same-cycle violation is recorded.
        viol_pending_d = viol_clr_i ? 1'b0 : viol_pending_q;
        viol_addr_d    = viol_clr_i ? '0   : viol_addr_q;
        viol_cnt_d     = viol_clr_i ? '0   : viol_cnt_q;

        if (wr_block_o) begin
            if (viol_cnt_d != c_cnt_max) begin
                viol_cnt_d = viol_cnt_d + 1'b1;
            end
            if (!viol_pending_d) begin
                viol_pending_d = 1'b1;
                viol_addr_d    = wr_addr_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_done_q    <= 1'b0;
            wp_q           <= '0;
            viol_pending_q <= 1'b0;
            viol_addr_q    <= '0;
            viol_cnt_q     <= '0;
        end else begin
            boot_done_q    <= boot_done_d;
            wp_q           <= wp_d;
            viol_pending_q <= viol_pending_d;
            viol_addr_q    <= viol_addr_d;
            viol_cnt_q     <= viol_cnt_d;
        end
    end

    assign viol_pending_o = viol_pending_q;
    assign viol_addr_o    = viol_addr_q;
    assign viol_cnt_o     = viol_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_code_wp_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_wp_bank
// Description : Self-checking bench for code_wp_bank against a region model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_wp_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lock_i = 1'b0;
    logic        wp_set_i = 1'b0;
    logic [3:0]  wp_set_mask_i = '0;
    logic        manuf_mode_i = 1'b0;
    logic        wr_valid_i = 1'b0;
    logic [31:0] wr_addr_i = '0;
    logic        wr_block_o;
    logic [3:0]  wp_q;
    logic        viol_pending_o;
    logic [31:0] viol_addr_o;
    logic [7:0]  viol_cnt_o;
    logic        viol_clr_i = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    bit [3:0]    m_wp;
    bit          m_boot;
    bit          m_pend;
    logic [31:0] m_addr;
    int          m_cnt;

    code_wp_bank #(
        .NREG(4), .AW(32), .REGION_BASE(32'h0000_0000), .REGION_SHIFT(12),
        .BOOT_MASK(4'b0001), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lock_i(lock_i), .wp_set_i(wp_set_i),
        .wp_set_mask_i(wp_set_mask_i), .manuf_mode_i(manuf_mode_i),
        .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_block_o(wr_block_o),
        .wp_q(wp_q), .viol_pending_o(viol_pending_o), .viol_addr_o(viol_addr_o),
        .viol_cnt_o(viol_cnt_o), .viol_clr_i(viol_clr_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Region size 4 KiB, four regions starting at byte 0.
    function automatic bit m_blocks(input bit valid, input logic [31:0] addr);
        longint idx;
        if (!valid) return 1'b0;
        idx = longint'(addr) / 4096;
        if (idx >= 4) return 1'b0;
        return m_wp[idx];
    endfunction

    task automatic check_state(input string where);
        check({where, ".wp"},   64'(wp_q),           64'(m_wp));
        check({where, ".pend"}, 64'(viol_pending_o), 64'(m_pend));
        check({where, ".addr"}, 64'(viol_addr_o),    64'(m_addr));
        check({where, ".cnt"},  64'(viol_cnt_o),     64'(m_cnt));
    endtask

    // Apply one cycle of inputs, check the combinational block, then the edge result.
    task automatic step(input bit lock, input bit set, input logic [3:0] mask,
                        input bit manuf, input bit valid, input logic [31:0] addr,
                        input bit clr);
        bit bl;
        @(negedge clk);
        lock_i = lock; wp_set_i = set; wp_set_mask_i = mask; manuf_mode_i = manuf;
        wr_valid_i = valid; wr_addr_i = addr; viol_clr_i = clr;
        #1;
        bl = m_blocks(valid, addr);
        check("wr_block", 64'(wr_block_o), 64'(bl));
        @(posedge clk);
        if (lock) m_wp = 4'hF;
        if (set) m_wp = m_wp | mask;
        if (!m_boot && !manuf) m_wp = m_wp | 4'b0001;
        m_boot = 1'b1;
        if (clr) begin m_pend = 0; m_addr = 0; m_cnt = 0; end
        if (bl) begin
            if (m_cnt < 255) m_cnt++;
            if (!m_pend) begin m_pend = 1; m_addr = addr; end
        end
        #1;
        check_state("post_edge");
    endtask

    task automatic idle(input bit manuf);
        step(0, 0, 4'h0, manuf, 0, 32'h0, 0);
    endtask

    task automatic write(input logic [31:0] addr);
        step(0, 0, 4'h0, 0, 1, addr, 0);
    endtask

    // Assert reset between edges so only an asynchronous reset clears state here.
    task automatic do_reset(input bit manuf);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_wp = 0; m_boot = 0; m_pend = 0; m_addr = 0; m_cnt = 0;
        check_state("in_reset");
        lock_i = 0; wp_set_i = 0; wp_set_mask_i = 0; manuf_mode_i = manuf;
        wr_valid_i = 0; wr_addr_i = 0; viol_clr_i = 0;
        @(posedge clk);
        #1;
        check_state("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] first_addr;

        // Boot with auto-protect of region 0
        do_reset(0);
        idle(0);
        check("boot.wp", 64'(wp_q), 64'h1);
        write(32'h0000_0010);
        check("boot.viol_addr", 64'(viol_addr_o), 64'h10);
        check("boot.viol_cnt", 64'(viol_cnt_o), 64'h1);

        // Manufacturing mode: nothing auto-protected
        do_reset(1);
        idle(1);
        check("manuf.wp", 64'(wp_q), 64'h0);
        write(32'h0);
        step(0, 1, 4'b0100, 1, 0, 32'h0, 0);
        check("manuf.set_wp", 64'(wp_q), 64'h4);
        write(32'h2000);
        write(32'h1000);

        // LOCK is sticky across a long idle stretch
        step(1, 0, 4'h0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 100; i++) idle(0);
        check("lock.wp", 64'(wp_q), 64'hF);
        step(0, 1, 4'h0, 0, 0, 32'h0, 0);

        // Clear coinciding with a new violation
        do_reset(0);
        idle(0);
        for (int i = 0; i < 5; i++) write(32'h10);
        check("clrviol.pre_cnt", 64'(viol_cnt_o), 64'h5);
        step(0, 0, 4'h0, 0, 1, 32'h0000_0abc, 1);
        check("clrviol.addr", 64'(viol_addr_o), 64'habc);
        check("clrviol.cnt", 64'(viol_cnt_o), 64'h1);
        step(0, 0, 4'h0, 0, 0, 32'h0, 1);

        // Counter saturation, first address retained
        first_addr = 32'h0000_0124;
        write(first_addr);
        for (int i = 1; i < 300; i++) write($urandom_range(0, 32'hFFF));
        check("sat.cnt", 64'(viol_cnt_o), 64'd255);
        check("sat.addr", 64'(viol_addr_o), 64'(first_addr));

        // Out-of-range write and same-cycle set
        do_reset(1);
        idle(1);
        write(32'h4000);
        step(0, 1, 4'b0010, 1, 1, 32'h1000, 0);
        write(32'h1000);
        check("samecyc.cnt", 64'(viol_cnt_o), 64'h1);

        // Randomized traffic with occasional mid-run resets
        for (int r = 0; r < 3; r++) begin
            bit mm;
            mm = 1'($urandom_range(0, 1));
            do_reset(mm);
            for (int i = 0; i < 300; i++) begin
                bit          lk, st, vl, cl;
                logic [3:0]  mk;
                logic [31:0] ad;
                lk = ($urandom_range(0, 199) == 0);
                st = ($urandom_range(0, 7) == 0);
                mk = 4'($urandom);
                vl = 1'($urandom_range(0, 1));
                cl = ($urandom_range(0, 15) == 0);
                ad = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 32'h5FFF));
                step(lk, st, mk, mm, vl, ad, cl);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
